wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port. Shares it between the pipeline WB stage (regSel
//  result mux) and results returned by the long-latency multiply/divide unit (MDU).
//  MDU results are buffered in a small FIFO. The FIFO drains on idle WB cycles, or is forced
//  via a one-cycle WB stall after MAX_WAIT lost cycles. Exports a pending-destination mask to
//  the hazard unit.
// PARAMETERS
//  DEPTH     2  MDU result FIFO entries (power of 2, >=2)
//  MAX_WAIT  4  consecutive cycles a valid FIFO head may lose the port before a forced write
// PORTS
//  CLK        in   1   system clock, all state on rising edge
//  RST        in   1   asynchronous, active-high reset
//  wb_valid   in   1   WB stage holds a committed instruction this cycle
//  regWr      in   1   WB instruction writes a register
//  regSel     in   regsel_t   WB data select: ALU / LUI / DMEM / NPC
//  regDst     in   5   WB destination register
//  nPC, ALUOut, lui, dmemload  in  32  WB candidate data
//  mdu_valid  in   1   MDU result offered
//  mdu_ready  out  1   FIFO accepts MDU result
//  mdu_dst    in   5   MDU destination register
//  mdu_data   in   32  MDU result
//  WEN        out  1   register-file write enable
//  wsel       out  5   register-file write select
//  wdat       out  32  register-file write data
//  wb_stall   out  1   WB must hold; its write is replayed next cycle
//  pend_mask  out  32  bit r set iff a live FIFO entry targets register r
// BEHAVIOUR
//  - Reset (async, RST=1): FIFO empty, pointers/count/wait_cnt=0. While RST is asserted,
//    WEN/mdu_ready/wb_stall=0 and pend_mask=0.
//  - pipe_req = wb_valid & regWr & (regDst!=0).
//  - pipe_dat is selected by regSel: ALUOut / lui / dmemload / nPC.
//  - Each entry holds {live, dst, data}. An enqueued entry is live only if mdu_dst!=0.
//  - mdu_ready = !full. Enqueue happens at the edge when mdu_valid & mdu_ready. An entry is
//    first eligible to write the cycle after enqueue.
//  - force = head live & (wait_cnt==MAX_WAIT).
//  - Grant, combinational, same cycle:
//    - force: write head; wb_stall = pipe_req.
//    - else pipe_req: write {regDst, pipe_dat}.
//    - else head live: write head.
//    - else WEN=0.
//  - Latency: a WB write lands in the same cycle (0 added). An MDU write lands >=1 cycle after
//    accept and <= MAX_WAIT+1 cycles after reaching the head.
//  - Pop: the head pops when granted, or when it is dead (no port use). A dead head pops while
//    the pipeline writes in the same cycle.
//  - wait_cnt:
//    - +1 when head live and not granted;
//    - 0 on pop or when empty;
//    - saturates at MAX_WAIT.
//  - Supersede: when the pipeline write is granted to reg R, every FIFO entry with dst R is
//    killed (live=0). An MDU result enqueued in the same cycle with dst R enters dead: MDU
//    results are older than the WB instruction.
//  - Two live entries with the same dst are written in FIFO order.
//  - pend_mask is an OR over live entries, decoded from state only. Bit 0 is always 0.
//  - Pointers wrap modulo DEPTH. count range 0..DEPTH. Simultaneous push+pop keeps count.
//  - flush and ihit/dhit do not affect this block: WB is committed.
//  - RST mid-operation drops all buffered results.
// STRUCTURE
//  - mdu_wb_entry_t {logic live; regbits_t dst; word_t data;} goes in cpu_types_pkg.
//  - regsel_t comes from control_unit_pkg.
//  - Sub-module wb_pend_fifo: DEPTH-entry FIFO with per-entry kill-by-dst compare and
//    pend_mask decode. Grant/wait/stall logic lives in the top module.
// TESTING
//  1 Reset: RST=1 with mdu_valid=1 -> WEN=0, mdu_ready=0, pend_mask=0. Release -> mdu_ready=1.
//  2 WB only: regWr=1, regDst=8, regSel=LUI, lui=32'hABCD0000 -> same cycle WEN=1, wsel=8,
//    wdat=32'hABCD0000. regDst=0 -> WEN=0.
//  3 Idle drain: push {dst=5, data=32'h12} with WB idle -> next cycle WEN=1, wsel=5, wdat=12.
//    pend_mask[5] is 1 for exactly one cycle.
//  4 Starvation: push {dst=9}, then pipe_req every cycle -> 4 WB writes, then in cycle 5
//    wsel=9, wb_stall=1. The WB write follows next cycle.
//  5 Supersede: FIFO holds {dst=3}. Pipeline writes reg 3 -> entry killed, never written,
//    pend_mask[3]=0 next cycle.
//  6 Full: push 2 entries with WB busy -> mdu_ready=0. A third offer is held, accepted after
//    the first pop. Data order is preserved.

Source files
------------

// File: rtl/control_unit_pkg.sv
`default_nettype none
// control_unit_pkg: control encodings shared between the decoder and the write-back stage.
// Revision 1.0 - initial release.
package control_unit_pkg;
   typedef enum logic [1:0] {
      REGSEL_ALU  = 2'd0,
      REGSEL_LUI  = 2'd1,
      REGSEL_DMEM = 2'd2,
      REGSEL_NPC  = 2'd3
   } regsel_t;
endpackage
`default_nettype wire

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// cpu_types_pkg: shared datapath types for the core (word, register index, MDU write-back entry).
// Revision 1.0 - initial release.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef struct packed {
      logic     live;
      regbits_t dst;
      word_t    data;
   } mdu_wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/wb_pend_fifo.sv
`default_nettype none
// wb_pend_fifo: MDU result FIFO with kill-by-destination and pending-destination mask decode.
// Revision 1.0 - initial release.
module wb_pend_fifo
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  regbits_t      push_dst,
   input  word_t         push_data,
   input  logic          pop,
   input  logic          kill_en,
   input  regbits_t      kill_dst,
   output logic          full,
   output logic          empty,
   output mdu_wb_entry_t head,
   output logic [31:0]   pend_mask
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mdu_wb_entry_t mem_q [DEPTH];
   mdu_wb_entry_t mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);

   always_comb begin
      head = mem_q[rd_ptr_q];
      if (empty) head.live = 1'b0;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_en && (mem_q[i].dst == kill_dst)) mem_d[i].live = 1'b0;
      end
      // Popped slots are cleared so the mask never sees stale entries.
      if (pop) begin
         mem_d[rd_ptr_q].live = 1'b0;
         rd_ptr_d             = rd_ptr_q + 1'b1;
      end
      if (push) begin
         mem_d[wr_ptr_q].live = (push_dst != '0) && !(kill_en && (kill_dst == push_dst));
         mem_d[wr_ptr_q].dst  = push_dst;
         mem_d[wr_ptr_q].data = push_data;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!push && pop) count_d = count_q - (PW+1)'(1);
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem_q[i].live) pend_mask[mem_q[i].dst] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// wb_port_arbiter: shares the register-file write port between the WB stage and buffered MDU results.
// Revision 1.0 - initial release.
module wb_port_arbiter
   import cpu_types_pkg::*;
   import control_unit_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        wb_valid,
   input  logic        regWr,
   input  regsel_t     regSel,
   input  logic [4:0]  regDst,
   input  logic [31:0] nPC,
   input  logic [31:0] ALUOut,
   input  logic [31:0] lui,
   input  logic [31:0] dmemload,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_dst,
   input  logic [31:0] mdu_data,
   output logic        WEN,
   output logic [4:0]  wsel,
   output logic [31:0] wdat,
   output logic        wb_stall,
   output logic [31:0] pend_mask
);
   localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic          pipe_req, force_wr, grant_head, grant_pipe, pop, push, full, empty;
   word_t         pipe_dat;
   mdu_wb_entry_t head;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;

   assign pipe_req = wb_valid & regWr & (regDst != '0);

   always_comb begin
      unique case (regSel)
         REGSEL_ALU:  pipe_dat = ALUOut;
         REGSEL_LUI:  pipe_dat = lui;
         REGSEL_DMEM: pipe_dat = dmemload;
         REGSEL_NPC:  pipe_dat = nPC;
         default:     pipe_dat = ALUOut;
      endcase
   end

   assign force_wr   = head.live & (wait_cnt_q == WW'(MAX_WAIT));
   assign grant_head = force_wr | (head.live & ~pipe_req);
   assign grant_pipe = pipe_req & ~force_wr;
   // A dead head is discarded without using the port, so it may pop alongside a pipeline write.
   assign pop        = ~empty & (grant_head | ~head.live);
   assign push       = mdu_valid & mdu_ready;

   assign mdu_ready = ~RST & ~full;
   assign WEN       = ~RST & (grant_head | grant_pipe);
   assign wb_stall  = ~RST & force_wr & pipe_req;
   assign wsel      = grant_head ? head.dst  : (grant_pipe ? regDst   : '0);
   assign wdat      = grant_head ? head.data : (grant_pipe ? pipe_dat : '0);

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (pop || empty)                                       wait_cnt_d = '0;
      else if (head.live && !grant_head && (wait_cnt_q != WW'(MAX_WAIT))) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) wait_cnt_q <= '0;
      else     wait_cnt_q <= wait_cnt_d;
   end

   wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push),
      .push_dst  (mdu_dst),
      .push_data (mdu_data),
      .pop       (pop),
      .kill_en   (grant_pipe),
      .kill_dst  (regDst),
      .full      (full),
      .empty     (empty),
      .head      (head),
      .pend_mask (pend_mask)
   );
endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// tb_wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Revision 1.0 - initial release.
module tb_wb_port_arbiter;
   import control_unit_pkg::*;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic        CLK, RST, wb_valid, regWr, mdu_valid, mdu_ready, WEN, wb_stall;
   regsel_t     regSel;
   logic [4:0]  regDst, mdu_dst, wsel;
   logic [31:0] nPC, ALUOut, lui, dmemload, mdu_data, wdat, pend_mask;

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit        live;
      bit [4:0]  dst;
      bit [31:0] data;
   } ent_t;

   wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .CLK(CLK), .RST(RST), .wb_valid(wb_valid), .regWr(regWr), .regSel(regSel),
      .regDst(regDst), .nPC(nPC), .ALUOut(ALUOut), .lui(lui), .dmemload(dmemload),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dst(mdu_dst), .mdu_data(mdu_data),
      .WEN(WEN), .wsel(wsel), .wdat(wdat), .wb_stall(wb_stall), .pend_mask(pend_mask)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic test_reset();
      RST = 1'b1; mdu_valid = 1'b1; mdu_dst = 5'd5; mdu_data = 32'h1;
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd8;
      tick(); tick();
      checks++; if (WEN !== 1'b0) $display("FAIL reset_wen: got %b want 0", WEN); else passes++;
      checks++; if (mdu_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", mdu_ready); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL reset_pend: got %h want 0", pend_mask); else passes++;
      checks++; if (wb_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", wb_stall); else passes++;
      mdu_valid = 1'b0; wb_valid = 1'b0; RST = 1'b0;
      #1;
      checks++; if (mdu_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", mdu_ready); else passes++;
      tick();
   endtask

   task automatic test_wb_only();
      logic [31:0] exp;
      ALUOut = 32'h1111_0001; lui = 32'hABCD_0000; dmemload = 32'h3333_0003; nPC = 32'h4444_0004;
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd8;
      for (int s = 0; s < 4; s++) begin
         regSel = regsel_t'(s[1:0]);
         exp = (s == 0) ? ALUOut : (s == 1) ? 32'hABCD_0000 : (s == 2) ? 32'h3333_0003 : 32'h4444_0004;
         #1;
         checks++; if (WEN !== 1'b1) $display("FAIL wb_wen sel%0d: got %b want 1", s, WEN); else passes++;
         checks++; if (wsel !== 5'd8) $display("FAIL wb_wsel sel%0d: got %0d want 8", s, wsel); else passes++;
         checks++; if (wdat !== exp) $display("FAIL wb_wdat sel%0d: got %h want %h", s, wdat, exp); else passes++;
         tick();
      end
      regDst = 5'd0; #1;
      checks++; if (WEN !== 1'b0) $display("FAIL wb_r0_wen: got %b want 0", WEN); else passes++;
      tick();
      regDst = 5'd8; regWr = 1'b0; #1;
      checks++; if (WEN !== 1'b0) $display("FAIL wb_nowr_wen: got %b want 0", WEN); else passes++;
      wb_valid = 1'b0;
      tick();
   endtask

   task automatic test_idle_drain();
      wb_valid = 1'b0; mdu_valid = 1'b1; mdu_dst = 5'd5; mdu_data = 32'h12;
      #1;
      checks++; if (mdu_ready !== 1'b1) $display("FAIL drain_ready: got %b want 1", mdu_ready); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL drain_pend_pre: got %h want 0", pend_mask); else passes++;
      tick();
      mdu_valid = 1'b0; #1;
      checks++; if (WEN !== 1'b1) $display("FAIL drain_wen: got %b want 1", WEN); else passes++;
      checks++; if (wsel !== 5'd5) $display("FAIL drain_wsel: got %0d want 5", wsel); else passes++;
      checks++; if (wdat !== 32'h12) $display("FAIL drain_wdat: got %h want 12", wdat); else passes++;
      checks++; if (pend_mask !== 32'h20) $display("FAIL drain_pend: got %h want 20", pend_mask); else passes++;
      tick(); #1;
      checks++; if (WEN !== 1'b0) $display("FAIL drain_after_wen: got %b want 0", WEN); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL drain_after_pend: got %h want 0", pend_mask); else passes++;
      tick();
   endtask

   task automatic test_starvation();
      mdu_valid = 1'b1; mdu_dst = 5'd9; mdu_data = 32'h99;
      tick();
      mdu_valid = 1'b0;
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd10; regSel = REGSEL_ALU; ALUOut = 32'hA5A5_0000;
      for (int c = 1; c <= MAX_WAIT; c++) begin
         #1;
         checks++; if (wsel !== 5'd10) $display("FAIL starve_wsel c%0d: got %0d want 10", c, wsel); else passes++;
         checks++; if (wb_stall !== 1'b0) $display("FAIL starve_stall c%0d: got %b want 0", c, wb_stall); else passes++;
         checks++; if (pend_mask !== 32'h200) $display("FAIL starve_pend c%0d: got %h want 200", c, pend_mask); else passes++;
         tick();
      end
      #1;
      checks++; if (wsel !== 5'd9) $display("FAIL force_wsel: got %0d want 9", wsel); else passes++;
      checks++; if (wdat !== 32'h99) $display("FAIL force_wdat: got %h want 99", wdat); else passes++;
      checks++; if (wb_stall !== 1'b1) $display("FAIL force_stall: got %b want 1", wb_stall); else passes++;
      tick(); #1;
      checks++; if (wsel !== 5'd10) $display("FAIL replay_wsel: got %0d want 10", wsel); else passes++;
      checks++; if (wb_stall !== 1'b0) $display("FAIL replay_stall: got %b want 0", wb_stall); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL replay_pend: got %h want 0", pend_mask); else passes++;
      wb_valid = 1'b0;
      tick();
   endtask

   task automatic test_supersede();
      mdu_valid = 1'b1; mdu_dst = 5'd3; mdu_data = 32'h33;
      tick();
      mdu_valid = 1'b0;
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd3; regSel = REGSEL_ALU; ALUOut = 32'h77;
      #1;
      checks++; if (wsel !== 5'd3) $display("FAIL sup_wsel: got %0d want 3", wsel); else passes++;
      checks++; if (wdat !== 32'h77) $display("FAIL sup_wdat: got %h want 77", wdat); else passes++;
      checks++; if (pend_mask !== 32'h8) $display("FAIL sup_pend_pre: got %h want 8", pend_mask); else passes++;
      tick();
      wb_valid = 1'b0; #1;
      checks++; if (WEN !== 1'b0) $display("FAIL sup_killed_wen: got %b want 0", WEN); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL sup_pend_post: got %h want 0", pend_mask); else passes++;
      tick();
      // Same-cycle enqueue with the pipeline writing the same register enters dead.
      wb_valid = 1'b1; regDst = 5'd3; mdu_valid = 1'b1; mdu_dst = 5'd3; mdu_data = 32'h44;
      tick();
      wb_valid = 1'b0; mdu_valid = 1'b0; #1;
      checks++; if (WEN !== 1'b0) $display("FAIL sup_same_wen: got %b want 0", WEN); else passes++;
      checks++; if (pend_mask !== 32'h0) $display("FAIL sup_same_pend: got %h want 0", pend_mask); else passes++;
      tick();
   endtask

   task automatic test_full();
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd20; regSel = REGSEL_ALU; ALUOut = 32'h2020;
      mdu_valid = 1'b1; mdu_dst = 5'd11; mdu_data = 32'h111; #1;
      checks++; if (mdu_ready !== 1'b1) $display("FAIL full_ready0: got %b want 1", mdu_ready); else passes++;
      tick();
      mdu_dst = 5'd12; mdu_data = 32'h222; #1;
      checks++; if (mdu_ready !== 1'b1) $display("FAIL full_ready1: got %b want 1", mdu_ready); else passes++;
      checks++; if (wsel !== 5'd20) $display("FAIL full_wsel1: got %0d want 20", wsel); else passes++;
      tick();
      mdu_dst = 5'd13; mdu_data = 32'h333; #1;
      checks++; if (mdu_ready !== 1'b0) $display("FAIL full_ready2: got %b want 0", mdu_ready); else passes++;
      checks++; if (pend_mask !== 32'h1800) $display("FAIL full_pend: got %h want 1800", pend_mask); else passes++;
      tick();
      wb_valid = 1'b0; #1;
      checks++; if (mdu_ready !== 1'b0) $display("FAIL full_ready3: got %b want 0", mdu_ready); else passes++;
      checks++; if (wsel !== 5'd11 || wdat !== 32'h111) $display("FAIL full_first: got %0d/%h want 11/111", wsel, wdat); else passes++;
      tick(); #1;
      checks++; if (mdu_ready !== 1'b1) $display("FAIL full_ready4: got %b want 1", mdu_ready); else passes++;
      checks++; if (wsel !== 5'd12 || wdat !== 32'h222) $display("FAIL full_second: got %0d/%h want 12/222", wsel, wdat); else passes++;
      tick();
      mdu_valid = 1'b0; #1;
      checks++; if (wsel !== 5'd13 || wdat !== 32'h333) $display("FAIL full_third: got %0d/%h want 13/333", wsel, wdat); else passes++;
      tick(); #1;
      checks++; if (WEN !== 1'b0) $display("FAIL full_empty_wen: got %b want 0", WEN); else passes++;
      tick();
   endtask

   task automatic test_reset_mid();
      mdu_valid = 1'b1; mdu_dst = 5'd6; mdu_data = 32'h1;
      wb_valid = 1'b1; regWr = 1'b1; regDst = 5'd7;
      tick();
      mdu_valid = 1'b0; #1;
      checks++; if (pend_mask !== 32'h40) $display("FAIL rstmid_pend_pre: got %h want 40", pend_mask); else passes++;
      RST = 1'b1; #1;
      checks++; if (pend_mask !== 32'h0) $display("FAIL rstmid_pend: got %h want 0", pend_mask); else passes++;
      checks++; if (WEN !== 1'b0) $display("FAIL rstmid_wen: got %b want 0", WEN); else passes++;
      tick();
      RST = 1'b0; wb_valid = 1'b0; #1;
      checks++; if (WEN !== 1'b0 || pend_mask !== 32'h0) $display("FAIL rstmid_drop: got %b/%h want 0/0", WEN, pend_mask); else passes++;
      tick();
   endtask

   task automatic test_random(input int n);
      ent_t        q[$];
      ent_t        e;
      int          mwait;
      bit          preq, hlive, frc, gh, gp, e_wen, e_ready, e_stall, popped, was_empty;
      bit [4:0]    e_sel;
      bit [31:0]   e_dat, e_pend, pdat;
      mwait = 0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int c = 0; c < n; c++) begin
         wb_valid  = ($urandom_range(0, 9) != 0);
         regWr     = ($urandom_range(0, 9) != 0);
         regDst    = 5'($urandom_range(0, 5));
         regSel    = regsel_t'(2'($urandom_range(0, 3)));
         ALUOut    = $urandom; lui = $urandom; dmemload = $urandom; nPC = $urandom;
         mdu_valid = ($urandom_range(0, 2) == 0);
         mdu_dst   = 5'($urandom_range(0, 5));
         mdu_data  = $urandom;
         #1;
         preq = wb_valid && regWr && (regDst != 0);
         case (regSel)
            REGSEL_LUI:  pdat = lui;
            REGSEL_DMEM: pdat = dmemload;
            REGSEL_NPC:  pdat = nPC;
            default:     pdat = ALUOut;
         endcase
         hlive   = (q.size() > 0) && q[0].live;
         frc     = hlive && (mwait == MAX_WAIT);
         gh      = frc || (hlive && !preq);
         gp      = preq && !frc;
         e_wen   = gh || gp;
         e_sel   = gh ? q[0].dst : regDst;
         e_dat   = gh ? q[0].data : pdat;
         e_ready = (q.size() < DEPTH);
         e_stall = frc && preq;
         e_pend  = 32'h0;
         foreach (q[k]) if (q[k].live) e_pend[q[k].dst] = 1'b1;
         checks++; if (WEN !== e_wen) $display("FAIL rnd_wen c%0d: got %b want %b", c, WEN, e_wen); else passes++;
         checks++; if (wb_stall !== e_stall) $display("FAIL rnd_stall c%0d: got %b want %b", c, wb_stall, e_stall); else passes++;
         checks++; if (mdu_ready !== e_ready) $display("FAIL rnd_ready c%0d: got %b want %b", c, mdu_ready, e_ready); else passes++;
         checks++; if (pend_mask !== e_pend) $display("FAIL rnd_pend c%0d: got %h want %h", c, pend_mask, e_pend); else passes++;
         if (e_wen) begin
            checks++; if (wsel !== e_sel) $display("FAIL rnd_wsel c%0d: got %0d want %0d", c, wsel, e_sel); else passes++;
            checks++; if (wdat !== e_dat) $display("FAIL rnd_wdat c%0d: got %h want %h", c, wdat, e_dat); else passes++;
         end
         was_empty = (q.size() == 0);
         popped    = !was_empty && (gh || !q[0].live);
         if (gp) foreach (q[k]) if (q[k].dst == regDst) q[k].live = 1'b0;
         if (popped) void'(q.pop_front());
         if (mdu_valid && e_ready) begin
            e.live = (mdu_dst != 0) && !(gp && (regDst == mdu_dst));
            e.dst  = mdu_dst;
            e.data = mdu_data;
            q.push_back(e);
         end
         if (popped || was_empty)  mwait = 0;
         else if (hlive && !gh)    mwait = (mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT;
         tick();
      end
      wb_valid = 1'b0; mdu_valid = 1'b0;
   endtask

   initial begin
      RST = 1'b1; wb_valid = 1'b0; regWr = 1'b0; regSel = REGSEL_ALU; regDst = '0;
      nPC = '0; ALUOut = '0; lui = '0; dmemload = '0;
      mdu_valid = 1'b0; mdu_dst = '0; mdu_data = '0;
      test_reset();
      test_wb_only();
      test_idle_drain();
      test_starvation();
      test_supersede();
      test_full();
      test_reset_mid();
      test_random(600);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
